// File: rtl/dror_pkg.sv
// Shared constants for the coordinate-BRAM access path of the denoising block.
package dror_pkg;

    localparam int unsigned WORD_BYTES = 16;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    // Bit positions of each requester in a grant vector
    localparam int unsigned REQ_FEED  = 0;
    localparam int unsigned REQ_CACHE = 1;
    localparam int unsigned REQ_WR    = 2;
    localparam int unsigned NUM_REQ   = 3;

    localparam logic [15:0] WE_ALL = 16'hffff;

    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rd_tag_pipe.sv
// Shift register carrying {feed, cache} read tags alongside the BRAM read latency.
module rd_tag_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] tag_in,
    output logic [1:0] tag_out,
    output logic       busy
);

    logic [1:0] stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= 2'b00;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | (|stage_q[i]);
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates the shared x/y/z BRAM port between feeder, cache loader and outlier eraser,
// returning tagged read data after the BRAM latency.
module bram_port_arbiter
    import dror_pkg::*;
#(
    parameter int unsigned IDX_W        = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             feed_req,
    input  logic [IDX_W-1:0] feed_idx,
    output logic             feed_gnt,
    input  logic             cache_req,
    input  logic [IDX_W-1:0] cache_idx,
    output logic             cache_gnt,
    input  logic             wr_req,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [127:0]     wr_data_x,
    input  logic [127:0]     wr_data_y,
    input  logic [127:0]     wr_data_z,
    output logic             wr_gnt,
    output logic [127:0]     rdata_x,
    output logic [127:0]     rdata_y,
    output logic [127:0]     rdata_z,
    output logic             feed_rvalid,
    output logic             cache_rvalid,
    output logic             idle,
    output logic [31:0]      addr_x,
    output logic [31:0]      addr_y,
    output logic [31:0]      addr_z,
    output logic [127:0]     write_in_x,
    output logic [127:0]     write_in_y,
    output logic [127:0]     write_in_z,
    input  logic [127:0]     read_out_x,
    input  logic [127:0]     read_out_y,
    input  logic [127:0]     read_out_z,
    output logic             en_x,
    output logic             en_y,
    output logic             en_z,
    output logic             rst_x,
    output logic             rst_y,
    output logic             rst_z,
    output logic [15:0]      we_x,
    output logic [15:0]      we_y,
    output logic [15:0]      we_z
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 2);

    logic [STARVE_W-1:0] starve_q;
    logic [NUM_REQ-1:0]  gnt;
    logic                force_feed;
    logic [IDX_W-1:0]    sel_idx;

    logic [31:0]  addr_q;
    logic         en_q;
    logic [15:0]  we_q;
    logic [127:0] wdata_x_q, wdata_y_q, wdata_z_q;
    logic [1:0]   rd_tag_q;
    logic [1:0]   tag_out;
    logic         pipe_busy;

    always_comb begin
        gnt        = '0;
        force_feed = feed_req && (starve_q == STARVE_W'(STARVE_LIMIT));
        if (!reset) begin
            if (force_feed) begin
                gnt[REQ_FEED] = 1'b1;
            end else if (wr_req) begin
                gnt[REQ_WR] = 1'b1;
            end else if (cache_req) begin
                gnt[REQ_CACHE] = 1'b1;
            end else if (feed_req) begin
                gnt[REQ_FEED] = 1'b1;
            end
        end
    end

    // Address follows the winner, not the highest request, so a forced feed uses feed_idx
    always_comb begin
        if (gnt[REQ_WR]) begin
            sel_idx = wr_idx;
        end else if (gnt[REQ_CACHE]) begin
            sel_idx = cache_idx;
        end else begin
            sel_idx = feed_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q  <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            we_q      <= '0;
            wdata_x_q <= '0;
            wdata_y_q <= '0;
            wdata_z_q <= '0;
            rd_tag_q  <= 2'b00;
        end else begin
            if (feed_req && !gnt[REQ_FEED]) begin
                starve_q <= starve_q + 1'b1;
            end else begin
                starve_q <= '0;
            end
            en_q     <= |gnt;
            we_q     <= gnt[REQ_WR] ? WE_ALL : 16'h0000;
            rd_tag_q <= {gnt[REQ_FEED], gnt[REQ_CACHE]};
            if (|gnt) begin
                addr_q <= word_addr(32'(sel_idx));
            end
            if (gnt[REQ_WR]) begin
                wdata_x_q <= wr_data_x;
                wdata_y_q <= wr_data_y;
                wdata_z_q <= wr_data_z;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (rd_tag_q),
        .tag_out (tag_out),
        .busy    (pipe_busy)
    );

    assign feed_gnt  = gnt[REQ_FEED];
    assign cache_gnt = gnt[REQ_CACHE];
    assign wr_gnt    = gnt[REQ_WR];

    // Gate with reset so a tag landing in the reset cycle is dropped too
    assign feed_rvalid  = tag_out[1] & ~reset;
    assign cache_rvalid = tag_out[0] & ~reset;

    assign rdata_x = read_out_x;
    assign rdata_y = read_out_y;
    assign rdata_z = read_out_z;

    assign idle = !feed_req && !cache_req && !wr_req && !(|rd_tag_q) && !pipe_busy;

    assign addr_x     = addr_q;
    assign addr_y     = addr_q;
    assign addr_z     = addr_q;
    assign en_x       = en_q;
    assign en_y       = en_q;
    assign en_z       = en_q;
    assign we_x       = we_q;
    assign we_y       = we_q;
    assign we_z       = we_q;
    assign write_in_x = wdata_x_q;
    assign write_in_y = wdata_y_q;
    assign write_in_z = wdata_z_q;
    assign rst_x      = 1'b0;
    assign rst_y      = 1'b0;
    assign rst_z      = 1'b0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (read latency 1 and 2) each on a read-first BRAM model.
module tb_bram_port_arbiter;

    localparam int unsigned IDX_W        = 16;
    localparam int unsigned STARVE_LIMIT = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset, mem_init;
    logic             feed_req, cache_req, wr_req;
    logic [IDX_W-1:0] feed_idx, cache_idx, wr_idx;
    logic [127:0]     wr_data_x, wr_data_y, wr_data_z;

    logic         feed_gnt[2], cache_gnt[2], wr_gnt[2], feed_rvalid[2], cache_rvalid[2], idle[2];
    logic         en_x[2], en_y[2], en_z[2], rst_x[2], rst_y[2], rst_z[2];
    logic [15:0]  we_x[2], we_y[2], we_z[2];
    logic [31:0]  addr_x[2], addr_y[2], addr_z[2];
    logic [127:0] write_in_x[2], write_in_y[2], write_in_z[2];
    logic [127:0] read_out_x[2], read_out_y[2], read_out_z[2];
    logic [127:0] rdata_x[2], rdata_y[2], rdata_z[2];

    function automatic logic [127:0] pre_word(input int axis, input int i);
        return {32'hF00D_0000 + 32'(i), 32'(axis), 32'(i * 3 + 1), 32'hA5A5_0000 + 32'(axis)};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned RL = k + 1;
        logic [127:0] mem_x[64], mem_y[64], mem_z[64];
        logic [127:0] px[2], py[2], pz[2];

        bram_port_arbiter #(
            .IDX_W        (IDX_W),
            .READ_LATENCY (RL),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_dut (
            .clock        (clock),
            .reset        (reset),
            .feed_req     (feed_req),
            .feed_idx     (feed_idx),
            .feed_gnt     (feed_gnt[k]),
            .cache_req    (cache_req),
            .cache_idx    (cache_idx),
            .cache_gnt    (cache_gnt[k]),
            .wr_req       (wr_req),
            .wr_idx       (wr_idx),
            .wr_data_x    (wr_data_x),
            .wr_data_y    (wr_data_y),
            .wr_data_z    (wr_data_z),
            .wr_gnt       (wr_gnt[k]),
            .rdata_x      (rdata_x[k]),
            .rdata_y      (rdata_y[k]),
            .rdata_z      (rdata_z[k]),
            .feed_rvalid  (feed_rvalid[k]),
            .cache_rvalid (cache_rvalid[k]),
            .idle         (idle[k]),
            .addr_x       (addr_x[k]),
            .addr_y       (addr_y[k]),
            .addr_z       (addr_z[k]),
            .write_in_x   (write_in_x[k]),
            .write_in_y   (write_in_y[k]),
            .write_in_z   (write_in_z[k]),
            .read_out_x   (read_out_x[k]),
            .read_out_y   (read_out_y[k]),
            .read_out_z   (read_out_z[k]),
            .en_x         (en_x[k]),
            .en_y         (en_y[k]),
            .en_z         (en_z[k]),
            .rst_x        (rst_x[k]),
            .rst_y        (rst_y[k]),
            .rst_z        (rst_z[k]),
            .we_x         (we_x[k]),
            .we_y         (we_y[k]),
            .we_z         (we_z[k])
        );

        // Read-first single-port BRAM, output pipelined to RL cycles
        always @(posedge clock) begin
            if (mem_init) begin
                for (int i = 0; i < 64; i++) begin
                    mem_x[i] <= pre_word(0, i);
                    mem_y[i] <= pre_word(1, i);
                    mem_z[i] <= pre_word(2, i);
                end
            end else begin
                if (en_x[k]) begin
                    px[0] <= mem_x[addr_x[k][9:4]];
                    if (we_x[k] == 16'hffff) mem_x[addr_x[k][9:4]] <= write_in_x[k];
                end
                if (en_y[k]) begin
                    py[0] <= mem_y[addr_y[k][9:4]];
                    if (we_y[k] == 16'hffff) mem_y[addr_y[k][9:4]] <= write_in_y[k];
                end
                if (en_z[k]) begin
                    pz[0] <= mem_z[addr_z[k][9:4]];
                    if (we_z[k] == 16'hffff) mem_z[addr_z[k][9:4]] <= write_in_z[k];
                end
            end
            px[1] <= px[0];
            py[1] <= py[0];
            pz[1] <= pz[0];
        end

        assign read_out_x[k] = px[RL-1];
        assign read_out_y[k] = py[RL-1];
        assign read_out_z[k] = pz[RL-1];
    end

    // ---------------- reference model (latency-1 instance) ----------------
    typedef struct {
        int           due;
        bit           feed;
        logic [127:0] dx, dy, dz;
    } rd_t;

    int           n_cmp = 0, n_fail = 0, cyc = 0;
    int           streak;
    logic [31:0]  e_addr;
    logic         e_en;
    logic [15:0]  e_we;
    logic [127:0] e_wx, e_wy, e_wz;
    logic [127:0] ref_x[64], ref_y[64], ref_z[64];
    rd_t          rq[$];
    bit           mg_feed, mg_cache, mg_wr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        bit ef, ec, ew, due_now, exp_fv, exp_cv, exp_idle;
        ef = 0; ec = 0; ew = 0;
        if (!reset) begin
            if (feed_req && streak == STARVE_LIMIT) ef = 1;
            else if (wr_req)                        ew = 1;
            else if (cache_req)                     ec = 1;
            else if (feed_req)                      ef = 1;
        end
        chk("feed_gnt", feed_gnt[0], ef);
        chk("cache_gnt", cache_gnt[0], ec);
        chk("wr_gnt", wr_gnt[0], ew);
        chk("en", {en_x[0], en_y[0], en_z[0]}, {3{e_en}});
        chk("we", {we_x[0], we_y[0], we_z[0]}, {3{e_we}});
        chk("addr", {addr_x[0], addr_y[0], addr_z[0]}, {3{e_addr}});
        chk("write_in_x", write_in_x[0], e_wx);
        chk("write_in_y", write_in_y[0], e_wy);
        chk("write_in_z", write_in_z[0], e_wz);
        chk("rst", {rst_x[0], rst_y[0], rst_z[0]}, 0);

        due_now  = rq.size() > 0 && rq[0].due == cyc;
        exp_idle = !feed_req && !cache_req && !wr_req && rq.size() == 0;
        exp_fv   = due_now && rq[0].feed && !reset;
        exp_cv   = due_now && !rq[0].feed && !reset;
        chk("idle", idle[0], exp_idle);
        chk("feed_rvalid", feed_rvalid[0], exp_fv);
        chk("cache_rvalid", cache_rvalid[0], exp_cv);
        if (exp_fv || exp_cv) begin
            chk("rdata_x", rdata_x[0], rq[0].dx);
            chk("rdata_y", rdata_y[0], rq[0].dy);
            chk("rdata_z", rdata_z[0], rq[0].dz);
        end
        if (due_now) void'(rq.pop_front());

        mg_feed = ef; mg_cache = ec; mg_wr = ew;
        if (reset) begin
            streak = 0; e_addr = 0; e_en = 0; e_we = 0;
            e_wx = 0; e_wy = 0; e_wz = 0;
            rq.delete();
        end else begin
            streak = (feed_req && !ef) ? streak + 1 : 0;
            e_en   = ef | ec | ew;
            e_we   = ew ? 16'hffff : 16'h0000;
            if (ew) begin
                e_addr = 32'(wr_idx) * 16;
                e_wx = wr_data_x; e_wy = wr_data_y; e_wz = wr_data_z;
                ref_x[wr_idx[5:0]] = wr_data_x;
                ref_y[wr_idx[5:0]] = wr_data_y;
                ref_z[wr_idx[5:0]] = wr_data_z;
            end else if (ec) begin
                e_addr = 32'(cache_idx) * 16;
                rq.push_back(rd_t'{due: cyc + 2, feed: 0, dx: ref_x[cache_idx[5:0]],
                                   dy: ref_y[cache_idx[5:0]], dz: ref_z[cache_idx[5:0]]});
            end else if (ef) begin
                e_addr = 32'(feed_idx) * 16;
                rq.push_back(rd_t'{due: cyc + 2, feed: 1, dx: ref_x[feed_idx[5:0]],
                                   dy: ref_y[feed_idx[5:0]], dz: ref_z[feed_idx[5:0]]});
            end
        end
        cyc++;
    endtask

    task automatic at_neg();
        @(negedge clock);
        model_check();
    endtask

    task automatic to_pos();
        @(posedge clock);
        #1;
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            at_neg();
            to_pos();
        end
    endtask

    typedef struct {
        bit       f, c, w;
        bit [2:0] exp_gnt;  // {wr, cache, feed}
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         vt[8];
        logic [127:0] seen[$];
        int           denied;
        bit           got;

        vt[0] = '{0, 0, 0, 3'b000};
        vt[1] = '{1, 0, 0, 3'b001};
        vt[2] = '{0, 1, 0, 3'b010};
        vt[3] = '{1, 1, 0, 3'b010};
        vt[4] = '{0, 0, 1, 3'b100};
        vt[5] = '{1, 0, 1, 3'b100};
        vt[6] = '{0, 1, 1, 3'b100};
        vt[7] = '{1, 1, 1, 3'b100};

        for (int i = 0; i < 64; i++) begin
            ref_x[i] = pre_word(0, i);
            ref_y[i] = pre_word(1, i);
            ref_z[i] = pre_word(2, i);
        end
        streak = 0; e_addr = 0; e_en = 0; e_we = 0; e_wx = 0; e_wy = 0; e_wz = 0;
        feed_req = 0; cache_req = 0; wr_req = 0;
        feed_idx = 0; cache_idx = 0; wr_idx = 0;
        wr_data_x = 0; wr_data_y = 0; wr_data_z = 0;
        reset = 1; mem_init = 1;
        to_pos();
        mem_init = 0;
        cycle(2);
        reset = 0;
        cycle(1);

        // Priority table
        feed_idx = 33; cache_idx = 34; wr_idx = 40;
        wr_data_x = 128'h1111; wr_data_y = 128'h2222; wr_data_z = 128'h3333;
        for (int i = 0; i < 8; i++) begin
            feed_req = vt[i].f; cache_req = vt[i].c; wr_req = vt[i].w;
            at_neg();
            chk($sformatf("prio_vec%0d", i), {wr_gnt[0], cache_gnt[0], feed_gnt[0]},
                vt[i].exp_gnt);
            to_pos();
        end
        feed_req = 0; cache_req = 0; wr_req = 0;
        cycle(4);

        // Back-to-back feeder reads of words 0..2
        feed_req = 1;
        for (int k = 0; k <= 4; k++) begin
            if (k < 3) feed_idx = IDX_W'(k);
            else       feed_req = 0;
            at_neg();
            if (k < 3) chk("t1_feed_gnt", feed_gnt[0], 1);
            if (k >= 1 && k <= 3) chk("t1_addr", addr_x[0], 32'((k - 1) * 16));
            if (k >= 2) begin
                chk("t1_rvalid", feed_rvalid[0], 1);
                chk("t1_rdata", rdata_x[0], pre_word(0, k - 2));
            end
            to_pos();
        end
        cycle(3);

        // All three request together: write, then cache, then feed
        feed_req = 1; cache_req = 1; wr_req = 1;
        feed_idx = 10; cache_idx = 9; wr_idx = 5;
        wr_data_x = 128'hABCD; wr_data_y = 128'h1234; wr_data_z = 128'h5678;
        at_neg();
        chk("t2_gnts", {wr_gnt[0], cache_gnt[0], feed_gnt[0]}, 3'b100);
        to_pos();
        wr_req = 0;
        at_neg();
        chk("t2_we", we_x[0], 16'hffff);
        chk("t2_addr", addr_x[0], 32'h50);
        chk("t2_cache_gnt", {wr_gnt[0], cache_gnt[0], feed_gnt[0]}, 3'b010);
        to_pos();
        cache_req = 0;
        at_neg();
        chk("t2_feed_gnt", {wr_gnt[0], cache_gnt[0], feed_gnt[0]}, 3'b001);
        to_pos();
        feed_req = 0;
        cycle(4);

        // Starvation: two rounds of 8 denials then a forced feed grant
        wr_req = 1; wr_idx = 20; cache_req = 1; cache_idx = 21; feed_req = 1; feed_idx = 22;
        for (int r = 0; r < 2; r++) begin
            denied = 0; got = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                at_neg();
                if (feed_gnt[0]) got = 1;
                else denied++;
                to_pos();
            end
            chk($sformatf("t3_granted_r%0d", r), got, 1);
            chk($sformatf("t3_denied_r%0d", r), denied, 8);
        end
        feed_req = 0; cache_req = 0; wr_req = 0;
        cycle(4);

        // Read 7, overwrite 7 with zero, read 7 again
        for (int n = 0; n < 7; n++) begin
            case (n)
                0: begin cache_req = 1; cache_idx = 7; end
                1: begin
                    cache_req = 0; wr_req = 1; wr_idx = 7;
                    wr_data_x = 0; wr_data_y = 0; wr_data_z = 0;
                end
                2: begin wr_req = 0; cache_req = 1; cache_idx = 7; end
                default: cache_req = 0;
            endcase
            at_neg();
            if (cache_rvalid[0]) seen.push_back(rdata_x[0]);
            to_pos();
        end
        chk("t4_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("t4_old", seen[0], pre_word(0, 7));
            chk("t4_new", seen[1], 0);
        end

        // Reset one cycle after a cache grant on the latency-2 instance
        cache_req = 1; cache_idx = 3;
        at_neg();
        chk("t5_grant", cache_gnt[1], 1);
        to_pos();
        cache_req = 0; reset = 1;
        cycle(1);
        reset = 0;
        for (int n = 0; n < 10; n++) begin
            at_neg();
            chk("t5_no_rvalid", {cache_rvalid[1], feed_rvalid[1]}, 0);
            chk("t5_bram_ctl", {en_x[1], we_x[1], rst_x[1]}, 0);
            chk("t5_addr", addr_x[1], 0);
            chk("t5_write_in", write_in_x[1], 0);
            chk("t5_idle", {idle[1], idle[0]}, 2'b11);
            chk("t6_quiet", {en_x[0], en_y[0], en_z[0], we_x[0], we_y[0], we_z[0]}, 0);
            to_pos();
        end

        // Randomised traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            at_neg();
            to_pos();
            reset = 0;
            if (!feed_req || mg_feed) begin
                feed_req = ($urandom_range(0, 2) != 0);
                feed_idx = IDX_W'($urandom_range(0, 63));
            end
            if (!cache_req || mg_cache) begin
                cache_req = ($urandom_range(0, 1) != 0);
                cache_idx = IDX_W'($urandom_range(0, 63));
            end
            if (!wr_req || mg_wr) begin
                wr_req    = ($urandom_range(0, 2) == 0);
                wr_idx    = IDX_W'($urandom_range(0, 63));
                wr_data_x = {$urandom, $urandom, $urandom, $urandom};
                wr_data_y = {$urandom, $urandom, $urandom, $urandom};
                wr_data_z = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        feed_req = 0; cache_req = 0; wr_req = 0;
        cycle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single port of each of the three coordinate BRAMs (x, y, z) between three requesters:
  - the feeder stream (sequential 128-bit reads),
  - the cache loader (random reads for the core cache),
  - the outlier eraser (writes that clear points drained from the outlier FIFO).
- Sits between the denoising controller/FIFO side and the three BRAM ports.
- Replaces ad-hoc address muxing with a req/gnt handshake, fixed priority plus feeder anti-starvation, and tagged read-data return.

Parameters:
- IDX_W, 16, width of requester word index.
- READ_LATENCY, 1, BRAM cycles from registered address to valid read_out (1..3).
- STARVE_LIMIT, 8, consecutive denied cycles of a pending feed_req before the feeder is forced to win.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- feed_req  in  1  feeder read request
- feed_idx  in  IDX_W  feeder word index
- feed_gnt  out  1  feeder request accepted this cycle
- cache_req  in  1  cache-loader read request
- cache_idx  in  IDX_W  cache word index
- cache_gnt  out  1  cache request accepted this cycle
- wr_req  in  1  eraser write request
- wr_idx  in  IDX_W  word index to write
- wr_data_x / wr_data_y / wr_data_z  in  128 each  write data
- wr_gnt  out  1  write accepted this cycle
- rdata_x / rdata_y / rdata_z  out  128 each  returned read data
- feed_rvalid  out  1  rdata_* belongs to a feeder read
- cache_rvalid  out  1  rdata_* belongs to a cache read
- idle  out  1  no request pending and no read in flight
- addr_x / addr_y / addr_z  out  32 each  BRAM address
- write_in_x / write_in_y / write_in_z  out  128 each  BRAM write data
- read_out_x / read_out_y / read_out_z  in  128 each  BRAM read data
- en_x / en_y / en_z  out  1 each  BRAM enable
- rst_x / rst_y / rst_z  out  1 each  BRAM output reset
- we_x / we_y / we_z  out  16 each  BRAM byte write enables

Behaviour:
- Handshake:
  - A transfer occurs on a cycle where req && gnt.
  - Requester holds req and its idx/data stable until gnt.
  - gnt is combinational from the current reqs and the starve counter.
  - At most one gnt per cycle.
- Priority, default: wr > cache > feed.
- Anti-starvation:
  - starve_cnt increments each cycle feed_req=1 and feed_gnt=0; it clears on feed_gnt or when feed_req=0.
  - When starve_cnt == STARVE_LIMIT, feed wins that cycle regardless of the other requests.
- BRAM drive, registered on the edge ending the grant cycle T, valid in T+1:
  - addr_* = {zero-extend(idx), 4'b0}, a 16-byte stride per 128-bit word; all three BRAMs receive the same address.
  - en_* = 1 on any grant, else 0.
  - we_* = 16'hffff for a write grant, else 0.
  - write_in_* = wr_data_* on a write grant, else held.
  - rst_* are constant 0.
- Read return:
  - A tag pipe of depth READ_LATENCY carries {feed, cache}.
  - feed_rvalid / cache_rvalid assert in cycle T+1+READ_LATENCY for one cycle, with rdata_* = read_out_* combinationally in that cycle.
  - Full throughput: a new grant is possible every cycle.
- Read/write ordering: operations hit the BRAM in grant order. A read granted before a write to the same index returns the old data (BRAM read-first mode); a read granted after it returns the new data.
- idle = !feed_req && !cache_req && !wr_req && (tag pipe empty).
- Reset:
  - gnts, en_*, we_*, rst_*, rvalids = 0.
  - addr_* = 0, write_in_* = 0, starve_cnt = 0.
  - Tag pipe flushed: reads in flight at reset never produce rvalid.
  - idle = 1 once reqs are low.
- idx wrap: none; idx is used as given. The caller bounds it to the point cloud size.

Decomposition:
- Shared package (dror_pkg):
  - WORD_BYTES = 16.
  - Requester ID localparams: REQ_FEED, REQ_CACHE, REQ_WR.
  - WE_ALL = 16'hffff.
- One natural sub-module: rd_tag_pipe, the READ_LATENCY-deep shift register of {feed, cache} tags with a flush on reset.

Test Plan:
1. Feed only, feed_idx=0,1,2 on consecutive cycles.
   -> feed_gnt each cycle; addr_x=0x00,0x10,0x20 in T+1..T+3; feed_rvalid in T+2..T+4 with rdata_x equal to the preloaded words.
2. wr_req and cache_req and feed_req all asserted in one cycle, wr_idx=5.
   -> wr_gnt only; next cycle we_*=16'hffff, addr=0x50; cache granted the following cycle, then feed.
3. wr_req and cache_req held high continuously with feed_req high.
   -> feed denied 8 cycles, granted on cycle 9; starve_cnt returns to 0.
4. Read idx 7, then write idx 7 with 0 the next cycle, then read idx 7.
   -> first cache_rvalid returns the preload value; second returns 0.
5. READ_LATENCY=2, cache read granted, reset asserted the next cycle.
   -> no cache_rvalid ever; all BRAM outputs 0; idle=1 after release.
6. No requests for 10 cycles after reset.
   -> idle=1, en_*=0, we_*=0 throughout.
